// File: rtl/register_file_param_pkg.sv
// Shared defaults, read-latency encodings and read-source selection for the
// parametrised register file.
package register_file_param_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 2;

  localparam int READ_LAT_COMB = 0;
  localparam int READ_LAT_REG  = 1;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_BYPASS,
    SRC_ZERO
  } readSrc_e;

  // The hardwired zero entry wins over forwarding.
  function automatic readSrc_e selectSource(input logic isZero, input logic isBypass);
    if (isZero) begin
      return SRC_ZERO;
    end
    if (isBypass) begin
      return SRC_BYPASS;
    end
    return SRC_MEM;
  endfunction

endpackage

// File: rtl/register_file_param_read_port.sv
// One read port: address mux, zero-register and forwarding selection, and an
// optional output register that clears asynchronously.
module register_file_param_read_port
  import register_file_param_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int READ_LAT = READ_LAT_COMB,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    memData,
  input  logic [2**ADDR_W-1:0]                written,
  input  logic                                writeLegal,
  input  logic [ADDR_W-1:0]                   writeAddr,
  input  logic [DATA_W-1:0]                   writeData,
  input  logic [ADDR_W-1:0]                   readAddr,
  output logic [DATA_W-1:0]                   readData,
  output logic                                readValid
);

  logic              isZero;
  logic              isBypass;
  readSrc_e          src;
  logic [DATA_W-1:0] effData;
  logic              effValid;
  logic [DATA_W-1:0] dataReg;
  logic              validReg;

  assign isZero   = (ZERO_REG != 0) && (readAddr == '0);
  assign isBypass = (BYPASS != 0) && writeLegal && (writeAddr == readAddr);

  always_comb begin
    src      = selectSource(isZero, isBypass);
    effData  = memData[readAddr];
    effValid = written[readAddr];
    case (src)
      SRC_ZERO: begin
        effData  = '0;
        effValid = 1'b1;
      end
      SRC_BYPASS: begin
        effData  = writeData;
        effValid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg  <= '0;
      validReg <= 1'b0;
    end else begin
      dataReg  <= effData;
      validReg <= effValid;
    end
  end

  // The combinational path is forced to zero during reset so a pending
  // forward or the zero entry cannot leak out while rst_n is low.
  assign readData  = (READ_LAT == READ_LAT_REG) ? dataReg  : (rst_n ? effData  : '0);
  assign readValid = (READ_LAT == READ_LAT_REG) ? validReg : (rst_n && effValid);

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two read ports, sticky per-entry
// written flags, optional forwarding, optional hardwired zero entry.
module register_file_param
  import register_file_param_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int READ_LAT = READ_LAT_COMB,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteR,
  input  logic [DATA_W-1:0] WriteD,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [DATA_W-1:0] ReadD1,
  output logic [DATA_W-1:0] ReadD2,
  output logic              Valid1,
  output logic              Valid2
);

  localparam int N = 2**ADDR_W;

  logic [N-1:0][DATA_W-1:0] memData;
  logic [N-1:0]             written;
  logic [N-1:0]             writeEn;
  logic                     writeLegal;

  // Writes to the hardwired zero entry are dropped before decode.
  assign writeLegal = RegWrite && !((ZERO_REG != 0) && (WriteR == '0));

  generate
    for (genvar gi = 0; gi < N; gi++) begin : gEntry
      logic [DATA_W-1:0] entryReg;
      logic              flagReg;

      assign writeEn[gi] = writeLegal && (WriteR == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entryReg <= '0;
          flagReg  <= 1'b0;
        end else if (writeEn[gi]) begin
          entryReg <= WriteD;
          flagReg  <= 1'b1;
        end
      end

      assign memData[gi] = entryReg;
      assign written[gi] = flagReg;
    end
  endgenerate

  register_file_param_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) uPort1 (
    .clk(clk), .rst_n(rst_n), .memData(memData), .written(written),
    .writeLegal(writeLegal), .writeAddr(WriteR), .writeData(WriteD),
    .readAddr(Read1), .readData(ReadD1), .readValid(Valid1)
  );

  register_file_param_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) uPort2 (
    .clk(clk), .rst_n(rst_n), .memData(memData), .written(written),
    .writeLegal(writeLegal), .writeAddr(WriteR), .writeData(WriteD),
    .readAddr(Read2), .readData(ReadD2), .readValid(Valid2)
  );

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench driving four register file variants with shared stimulus:
// 0 default, 1 no forwarding, 2 registered read, 3 hardwired zero entry.
module tb_register_file_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RegWrite = 1'b0;
  logic [1:0] WriteR = 2'd0;
  logic [7:0] WriteD = 8'h00;
  logic [1:0] Read1 = 2'd0;
  logic [1:0] Read2 = 2'd0;

  logic [7:0] rd1 [4];
  logic [7:0] rd2 [4];
  logic       v1 [4];
  logic       v2 [4];

  always #10 clk = ~clk;

  register_file_param #(.READ_LAT(0), .BYPASS(1), .ZERO_REG(0)) uDutA (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rd1[0]), .ReadD2(rd2[0]), .Valid1(v1[0]), .Valid2(v2[0]));
  register_file_param #(.READ_LAT(0), .BYPASS(0), .ZERO_REG(0)) uDutB (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rd1[1]), .ReadD2(rd2[1]), .Valid1(v1[1]), .Valid2(v2[1]));
  register_file_param #(.READ_LAT(1), .BYPASS(1), .ZERO_REG(0)) uDutC (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rd1[2]), .ReadD2(rd2[2]), .Valid1(v1[2]), .Valid2(v2[2]));
  register_file_param #(.READ_LAT(0), .BYPASS(1), .ZERO_REG(1)) uDutD (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteR(WriteR), .WriteD(WriteD),
    .Read1(Read1), .Read2(Read2), .ReadD1(rd1[3]), .ReadD2(rd2[3]), .Valid1(v1[3]), .Valid2(v2[3]));

  typedef struct {
    int         dut;
    int         port;
    logic [7:0] d;
    logic       v;
  } expEntry_t;

  expEntry_t expQ[$];
  string     nameQ[$];
  int        nChecks = 0;
  int        nFails = 0;
  event      sampleEv;

  task automatic expectPort(input int dut, input int port, input logic [7:0] d,
                            input logic v, input string nm);
    expEntry_t e;
    e.dut  = dut;
    e.port = port;
    e.d    = d;
    e.v    = v;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic expectAll(input logic [7:0] d1, input logic vv1,
                           input logic [7:0] d2, input logic vv2, input string nm);
    for (int k = 0; k < 4; k++) begin
      expectPort(k, 1, d1, vv1, nm);
      expectPort(k, 2, d2, vv2, nm);
    end
  endtask

  task automatic sample();
    -> sampleEv;
    #1;
  endtask

  // Monitor: drains every queued expectation whenever a sample point is signalled.
  initial begin
    forever begin
      @(sampleEv);
      while (expQ.size() > 0) begin
        expEntry_t  e;
        string      nm;
        logic [7:0] ad;
        logic       av;
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        ad = (e.port == 1) ? rd1[e.dut] : rd2[e.dut];
        av = (e.port == 1) ? v1[e.dut] : v2[e.dut];
        nChecks += 2;
        if (ad !== e.d) begin
          nFails++;
          $display("FAIL %s dut%0d ReadD%0d: got %h expected %h", nm, e.dut, e.port, ad, e.d);
        end
        if (av !== e.v) begin
          nFails++;
          $display("FAIL %s dut%0d Valid%0d: got %b expected %b", nm, e.dut, e.port, av, e.v);
        end
      end
    end
  end

  logic [7:0] wv [4];

  initial begin
    wv[0] = 8'hAA; wv[1] = 8'hFF; wv[2] = 8'h11; wv[3] = 8'hAB;

    // Reset held while writes are attempted: everything reads zero and invalid.
    @(negedge clk);
    RegWrite = 1'b1;
    WriteD   = 8'hFF;
    for (int a = 0; a < 4; a++) begin
      WriteR = 2'(a);
      Read1  = 2'(a);
      Read2  = 2'(3 - a);
      @(negedge clk);
      expectAll(8'h00, 1'b0, 8'h00, 1'b0, "rst_sweep");
      sample();
      $display("reset sweep addr %0d", a);
    end
    RegWrite = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      RegWrite = 1'b1;
      WriteR   = 2'(i);
      WriteD   = wv[i];
      $display("write entry %0d <= %h", i, wv[i]);
    end
    @(negedge clk);
    RegWrite = 1'b0;
    Read1    = 2'd0;
    Read2    = 2'd1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      expectPort(k, 1, 8'hAA, 1'b1, "read01");
      expectPort(k, 2, 8'hFF, 1'b1, "read01");
    end
    expectPort(3, 1, 8'h00, 1'b1, "read01_zero");
    expectPort(3, 2, 8'hFF, 1'b1, "read01_zero");
    sample();
    $display("read (0,1)");
    Read1 = 2'd2;
    Read2 = 2'd3;
    @(negedge clk);
    expectAll(8'h11, 1'b1, 8'hAB, 1'b1, "read23");
    sample();
    $display("read (2,3)");

    // Forwarding before and after the write edge.
    RegWrite = 1'b1;
    WriteR   = 2'd2;
    WriteD   = 8'h5C;
    #1;
    expectPort(0, 1, 8'h5C, 1'b1, "fwd_pre");
    expectPort(1, 1, 8'h11, 1'b1, "fwd_pre_nobyp");
    expectPort(2, 1, 8'h11, 1'b1, "fwd_pre_lat1");
    expectPort(3, 1, 8'h5C, 1'b1, "fwd_pre");
    sample();
    @(posedge clk);
    #1;
    expectAll(8'h5C, 1'b1, 8'hAB, 1'b1, "fwd_post");
    sample();
    $display("forward entry 2 <= 5c");

    // Registered-read latency and same-edge forwarding.
    @(negedge clk);
    RegWrite = 1'b0;
    Read1    = 2'd0;
    @(posedge clk);
    #1;
    expectPort(2, 1, 8'hAA, 1'b1, "lat1_addr0");
    expectPort(0, 1, 8'hAA, 1'b1, "lat0_addr0");
    sample();
    @(negedge clk);
    Read1 = 2'd1;
    #1;
    expectPort(2, 1, 8'hAA, 1'b1, "lat1_hold");
    expectPort(0, 1, 8'hFF, 1'b1, "lat0_addr1");
    sample();
    @(posedge clk);
    #1;
    expectPort(2, 1, 8'hFF, 1'b1, "lat1_addr1");
    sample();
    @(negedge clk);
    RegWrite = 1'b1;
    WriteR   = 2'd1;
    WriteD   = 8'h3C;
    #1;
    expectPort(2, 1, 8'hFF, 1'b1, "lat1_pre_wr");
    expectPort(0, 1, 8'h3C, 1'b1, "byp_wr1");
    expectPort(1, 1, 8'hFF, 1'b1, "nobyp_wr1");
    sample();
    @(posedge clk);
    #1;
    expectPort(2, 1, 8'h3C, 1'b1, "lat1_same_edge");
    expectPort(1, 1, 8'h3C, 1'b1, "nobyp_post_wr1");
    sample();
    $display("latency checks on entry 1");

    // Zero register ignores writes and forwarding.
    @(negedge clk);
    WriteR = 2'd0;
    WriteD = 8'h77;
    Read1  = 2'd0;
    Read2  = 2'd1;
    #1;
    expectPort(3, 1, 8'h00, 1'b1, "zero_pre");
    expectPort(3, 2, 8'h3C, 1'b1, "zero_e1");
    expectPort(0, 1, 8'h77, 1'b1, "byp_e0");
    expectPort(1, 1, 8'hAA, 1'b1, "nobyp_e0");
    sample();
    @(posedge clk);
    #1;
    expectPort(3, 1, 8'h00, 1'b1, "zero_post");
    expectPort(3, 2, 8'h3C, 1'b1, "zero_e1_post");
    expectPort(1, 1, 8'h77, 1'b1, "nobyp_e0_post");
    expectPort(2, 1, 8'h77, 1'b1, "lat1_e0_post");
    sample();
    $display("zero register write 77");

    // Mid-cycle reset with a write pending.
    @(negedge clk);
    WriteR = 2'd3;
    WriteD = 8'h99;
    Read1  = 2'd3;
    Read2  = 2'd1;
    #1;
    expectPort(0, 1, 8'h99, 1'b1, "pre_reset_fwd");
    sample();
    #3;
    rst_n = 1'b0;
    #1;
    expectAll(8'h00, 1'b0, 8'h00, 1'b0, "async_reset");
    sample();
    repeat (2) @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    rst_n    = 1'b1;
    Read1    = 2'd0;
    Read2    = 2'd1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      expectPort(k, 1, 8'h00, 1'b0, "post_rst01");
      expectPort(k, 2, 8'h00, 1'b0, "post_rst01");
    end
    expectPort(3, 1, 8'h00, 1'b1, "post_rst_zero");
    expectPort(3, 2, 8'h00, 1'b0, "post_rst01");
    sample();
    @(negedge clk);
    Read1 = 2'd2;
    Read2 = 2'd3;
    @(posedge clk);
    #1;
    expectAll(8'h00, 1'b0, 8'h00, 1'b0, "post_rst23");
    sample();
    $display("mid-operation reset");

    @(negedge clk);
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
